// File: rtl/number_drawer_pkg.sv
// Shared definitions for the number_drawer block: FSM state encoding,
// LFSR tap masks and default sizing.
package number_drawer_pkg;

  // Draw controller states
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DRAW     = 2'd1,
    WAIT_REL = 2'd2
  } draw_state_t;

  localparam int DEFAULT_DATA_WIDTH      = 8;
  localparam int DEFAULT_MAX_NUMBER      = 90;
  localparam int DEFAULT_DEBOUNCE_CYCLES = 16;

  // x^8 + x^6 + x^5 + x^4 + 1, taps on bits 7,5,4,3 of a left-shifting register
  localparam logic [7:0] LFSR_TAPS_8 = 8'hB8;

  // Maximal-length Fibonacci tap masks for the supported widths.
  // Bit k of the mask corresponds to polynomial term x^(k+1).
  function automatic logic [31:0] lfsr_taps(input int width);
    logic [31:0] taps;
    case (width)
      3:       taps = 32'h0000_0006;  // x^3+x^2+1
      4:       taps = 32'h0000_000C;  // x^4+x^3+1
      5:       taps = 32'h0000_0014;  // x^5+x^3+1
      6:       taps = 32'h0000_0030;  // x^6+x^5+1
      7:       taps = 32'h0000_0060;  // x^7+x^6+1
      8:       taps = {24'h0, LFSR_TAPS_8};
      9:       taps = 32'h0000_0110;  // x^9+x^5+1
      10:      taps = 32'h0000_0240;  // x^10+x^7+1
      11:      taps = 32'h0000_0500;  // x^11+x^9+1
      12:      taps = 32'h0000_0829;  // x^12+x^6+x^4+x^1+1
      16:      taps = 32'h0000_D008;  // x^16+x^15+x^13+x^4+1
      default: taps = {24'h0, LFSR_TAPS_8};
    endcase
    return taps;
  endfunction

endpackage

// File: rtl/number_drawer_if.sv
// Control/result bundle between the game controller (master) and the
// number drawer (slave).
interface number_drawer_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  btn_next;
  logic                  new_game;
  logic [DATA_WIDTH-1:0] guessed_number;
  logic                  next_edge;
  logic [DATA_WIDTH-1:0] draw_count;
  logic                  exhausted;
  logic                  busy;

  modport master (
    output btn_next,
    output new_game,
    input  guessed_number,
    input  next_edge,
    input  draw_count,
    input  exhausted,
    input  busy
  );

  modport slave (
    input  btn_next,
    input  new_game,
    output guessed_number,
    output next_edge,
    output draw_count,
    output exhausted,
    output busy
  );
endinterface

// File: rtl/number_drawer_btn_debounce.sv
// Push-button conditioner: 2-FF synchronizer followed by a stable-high
// counter. Emits a single-cycle press pulse once the synced level has been
// high for DEBOUNCE_CYCLES consecutive cycles; the counter then saturates so
// a held button produces no further pulses.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rstn,
  input  logic btn_raw,
  input  logic clear,
  output logic level,
  output logic press
);

  // One count beyond the accept value is the saturation (already fired) state
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic          sync1_reg;
  logic          sync2_reg;
  logic [CW-1:0] count_reg;

  // Bring the asynchronous button into the clock domain
  always_ff @(posedge clk) begin
    if (!rstn) begin
      sync1_reg <= 1'b0;
      sync2_reg <= 1'b0;
    end else begin
      sync1_reg <= btn_raw;
      sync2_reg <= sync1_reg;
    end
  end

  // Count stable-high cycles; any low cycle or a clear restarts the count
  always_ff @(posedge clk) begin
    if (!rstn || clear || !sync2_reg) begin
      count_reg <= '0;
    end else if (count_reg != CW'(DEBOUNCE_CYCLES)) begin
      count_reg <= count_reg + 1'b1;
    end
  end

  assign level = sync2_reg;
  assign press = sync2_reg && (count_reg == CW'(DEBOUNCE_CYCLES - 1));

endmodule

// File: rtl/number_drawer.sv
// Non-repeating bingo number drawer. A debounced press draws one unused
// value in 1..MAX_NUMBER, presented on guessed_number with a one-cycle
// next_edge strobe. A used-number bitmap prevents repeats until new_game.
// Build option: define NUMBER_DRAWER_SEQ_EN to take candidates from a
// sequential 1..MAX_NUMBER counter instead of the LFSR (deterministic order).
module number_drawer
  import number_drawer_pkg::*;
#(
  parameter int                    DATA_WIDTH      = DEFAULT_DATA_WIDTH,
  parameter int                    MAX_NUMBER      = DEFAULT_MAX_NUMBER,
  parameter int                    DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter logic [DATA_WIDTH-1:0] LFSR_SEED       = DATA_WIDTH'('hA5)
) (
  input  logic           clk,
  input  logic           rstn,
  number_drawer_if.slave bus
);

  localparam int                    DEPTH   = 2 ** DATA_WIDTH;
  localparam logic [DATA_WIDTH-1:0] MAX_VAL = DATA_WIDTH'(MAX_NUMBER);

  draw_state_t           state_reg;
  draw_state_t           state_next;
  logic                  accept;
  logic                  press;
  logic                  btn_level;
  logic [DATA_WIDTH-1:0] candidate;
  logic                  cand_ok;
  logic [DEPTH-1:0]      used_reg;
  logic [DEPTH-1:0]      used_set;
  logic [DATA_WIDTH-1:0] guessed_number_reg;
  logic                  next_edge_reg;
  logic [DATA_WIDTH-1:0] draw_count_reg;
  logic                  exhausted_int;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_btn_debounce (
    .clk    (clk),
    .rstn   (rstn),
    .btn_raw(bus.btn_next),
    .clear  (bus.new_game),
    .level  (btn_level),
    .press  (press)
  );

`ifdef NUMBER_DRAWER_SEQ_EN
  logic [DATA_WIDTH-1:0] seq_reg;

  // Sequential candidate: walks 1..MAX_NUMBER only while drawing
  always_ff @(posedge clk) begin
    if (!rstn) begin
      seq_reg <= DATA_WIDTH'(1);
    end else if (state_reg == DRAW) begin
      seq_reg <= (seq_reg == MAX_VAL) ? DATA_WIDTH'(1) : seq_reg + 1'b1;
    end
  end

  assign candidate = seq_reg;
`else
  localparam logic [DATA_WIDTH-1:0] TAP_MASK = DATA_WIDTH'(lfsr_taps(DATA_WIDTH));

  logic [DATA_WIDTH-1:0] lfsr_reg;

  // Free-running Fibonacci LFSR; a non-zero seed keeps it off the zero state
  always_ff @(posedge clk) begin
    if (!rstn) begin
      lfsr_reg <= LFSR_SEED;
    end else begin
      lfsr_reg <= {lfsr_reg[DATA_WIDTH-2:0], ^(lfsr_reg & TAP_MASK)};
    end
  end

  assign candidate = lfsr_reg;
`endif

  assign cand_ok = (candidate != '0) && (candidate <= MAX_VAL) && !used_reg[candidate];

  // Per-value set strobes for the used bitmap
  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_used_set
      assign used_set[gi] = accept && (candidate == DATA_WIDTH'(gi));
    end
  endgenerate

  // Used-number bitmap; cleared as a whole on new_game
  always_ff @(posedge clk) begin
    if (!rstn || bus.new_game) begin
      used_reg <= '0;
    end else begin
      used_reg <= used_reg | used_set;
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state and accept decode; new_game overrides any press or accept
  always_comb begin
    state_next = state_reg;
    accept     = 1'b0;
    if (bus.new_game) begin
      state_next = IDLE;
    end else begin
      unique case (state_reg)
        IDLE: begin
          if (press) begin
            state_next = exhausted_int ? WAIT_REL : DRAW;
          end
        end
        DRAW: begin
          if (cand_ok) begin
            accept     = 1'b1;
            state_next = WAIT_REL;
          end
        end
        WAIT_REL: begin
          if (!btn_level) begin
            state_next = IDLE;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // Drawn value and its strobe, aligned on the cycle after the accept
  always_ff @(posedge clk) begin
    if (!rstn) begin
      guessed_number_reg <= '0;
      next_edge_reg      <= 1'b0;
    end else begin
      next_edge_reg <= accept;
      if (accept) begin
        guessed_number_reg <= candidate;
      end
    end
  end

  // Draw counter; cannot pass MAX_NUMBER since DRAW is only entered when not exhausted
  always_ff @(posedge clk) begin
    if (!rstn || bus.new_game) begin
      draw_count_reg <= '0;
    end else if (accept) begin
      draw_count_reg <= draw_count_reg + 1'b1;
    end
  end

  assign exhausted_int      = (draw_count_reg == MAX_VAL);
  assign bus.guessed_number = guessed_number_reg;
  assign bus.next_edge      = next_edge_reg;
  assign bus.draw_count     = draw_count_reg;
  assign bus.exhausted      = exhausted_int;
  assign bus.busy           = (state_reg == DRAW);

endmodule

// File: tb/tb_number_drawer.sv
// Self-checking bench for number_drawer: randomized press timing and bounce
// patterns, checked against a set/count model of the drawing rules.
module tb_number_drawer;

  localparam int DW    = 8;
  localparam int MAXN  = 90;
  localparam int DEB   = 4;
  localparam int LIMIT = DEB + 2 + 260;

  logic clk;
  logic rstn;

  number_drawer_if #(.DATA_WIDTH(DW)) bus ();

  number_drawer #(
    .DATA_WIDTH     (DW),
    .MAX_NUMBER     (MAXN),
    .DEBOUNCE_CYCLES(DEB),
    .LFSR_SEED      (8'hA5)
  ) dut (
    .clk (clk),
    .rstn(rstn),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model: which values have been drawn, how many, the latest one
  bit          used_m [0:255];
  int          count_m;
  logic [7:0]  last_m;
  int          seq_ptr;

  task automatic model_clear();
    for (int i = 0; i < 256; i++) used_m[i] = 1'b0;
    count_m = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Hold the button for 'hold' cycles and observe the DUT for 'limit' cycles
  task automatic do_press(input int hold, input int limit,
                          output int n_strobe, output int t_busy, output int t_edge,
                          output logic [7:0] val, output bit wide);
    n_strobe = 0; t_busy = -1; t_edge = -1; val = '0; wide = 1'b0;
    bus.btn_next = 1'b1;
    for (int n = 1; n <= limit; n++) begin
      tick();
      if (bus.busy && t_busy < 0) t_busy = n;
      if (bus.next_edge) begin
        if (t_edge >= 0 && n == t_edge + 1) begin
          wide = 1'b1;
        end else begin
          n_strobe++;
          if (t_edge < 0) begin
            t_edge = n;
            val    = bus.guessed_number;
          end
        end
      end
      if (n == hold) bus.btn_next = 1'b0;
    end
    bus.btn_next = 1'b0;
    repeat (4) tick();
  endtask

  task automatic test_reset();
    rstn = 1'b0; bus.btn_next = 1'b0; bus.new_game = 1'b0;
    repeat (3) tick();
    checks++; if (bus.guessed_number !== 8'd0) begin failures++; $display("FAIL reset_guessed: got %0d expected 0", bus.guessed_number); end
    checks++; if (bus.next_edge !== 1'b0) begin failures++; $display("FAIL reset_next_edge: got %0b expected 0", bus.next_edge); end
    checks++; if (bus.draw_count !== 8'd0) begin failures++; $display("FAIL reset_count: got %0d expected 0", bus.draw_count); end
    checks++; if (bus.exhausted !== 1'b0) begin failures++; $display("FAIL reset_exhausted: got %0b expected 0", bus.exhausted); end
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %0b expected 0", bus.busy); end
    rstn = 1'b1;
    repeat (2) tick();
    model_clear();
    seq_ptr = 1;
    $display("reset: outputs checked");
  endtask

  // Draw n values with random hold/gap, checking each against the model
  task automatic test_draws(input int n_draws, input string tag, input bit seq_check);
    int ns, tb_, te; logic [7:0] v; bit w;
    for (int k = 0; k < n_draws; k++) begin
      repeat ($urandom_range(0, 5)) tick();
      do_press($urandom_range(7, 20), LIMIT, ns, tb_, te, v, w);
      checks++;
      if (ns != 1) begin
        failures++; $display("FAIL %s_strobes: got %0d expected 1 (draw %0d)", tag, ns, count_m + 1);
      end else begin
        checks++; if (tb_ != DEB + 2) begin failures++; $display("FAIL %s_busy_delay: got %0d expected %0d", tag, tb_, DEB + 2); end
        checks++; if (te - tb_ < 1 || te - tb_ > 255) begin failures++; $display("FAIL %s_draw_latency: got %0d expected 1..255", tag, te - tb_); end
        checks++; if (v < 1 || v > MAXN) begin failures++; $display("FAIL %s_range: got %0d expected 1..%0d", tag, v, MAXN); end
        checks++; if (used_m[v]) begin failures++; $display("FAIL %s_repeat: got %0d expected an undrawn value", tag, v); end
        checks++; if (w) begin failures++; $display("FAIL %s_strobe_width: got 2+ cycles expected 1", tag); end
`ifdef NUMBER_DRAWER_SEQ_EN
        if (seq_check) begin
          checks++; if (v !== 8'(seq_ptr)) begin failures++; $display("FAIL %s_seq_value: got %0d expected %0d", tag, v, seq_ptr); end
          checks++; if (te - tb_ != 1) begin failures++; $display("FAIL %s_seq_latency: got %0d expected 1", tag, te - tb_); end
        end
`endif
        used_m[v] = 1'b1;
        count_m++;
        last_m = v;
        seq_ptr = (seq_ptr == MAXN) ? 1 : seq_ptr + 1;
      end
      checks++; if (bus.draw_count !== 8'(count_m)) begin failures++; $display("FAIL %s_count: got %0d expected %0d", tag, bus.draw_count, count_m); end
      checks++; if (bus.guessed_number !== last_m) begin failures++; $display("FAIL %s_hold_value: got %0d expected %0d", tag, bus.guessed_number, last_m); end
      $display("%s: draw %0d value %0d latency %0d", tag, count_m, v, te - tb_);
    end
  endtask

  task automatic test_bounce();
    int spurious, ns, tb_, te; logic [7:0] v; bit w;
    spurious = 0;
    for (int b = 0; b < 4; b++) begin
      bus.btn_next = 1'b1;
      repeat ($urandom_range(1, 3)) begin tick(); if (bus.busy || bus.next_edge) spurious++; end
      bus.btn_next = 1'b0;
      repeat ($urandom_range(1, 2)) begin tick(); if (bus.busy || bus.next_edge) spurious++; end
    end
    repeat (3) begin tick(); if (bus.busy || bus.next_edge) spurious++; end
    checks++; if (spurious != 0) begin failures++; $display("FAIL bounce_spurious: got %0d active cycles expected 0", spurious); end
    do_press(10, LIMIT, ns, tb_, te, v, w);
    checks++; if (ns != 1) begin failures++; $display("FAIL bounce_strobes: got %0d expected 1", ns); end
    checks++; if (tb_ != DEB + 2) begin failures++; $display("FAIL bounce_busy_delay: got %0d expected %0d", tb_, DEB + 2); end
`ifdef NUMBER_DRAWER_SEQ_EN
    checks++; if (te != DEB + 3) begin failures++; $display("FAIL bounce_edge_delay: got %0d expected %0d", te, DEB + 3); end
    checks++; if (v !== 8'(seq_ptr)) begin failures++; $display("FAIL bounce_seq_value: got %0d expected %0d", v, seq_ptr); end
`endif
    if (ns == 1) begin
      checks++; if (v < 1 || v > MAXN || used_m[v]) begin failures++; $display("FAIL bounce_value: got %0d expected undrawn 1..%0d", v, MAXN); end
      used_m[v] = 1'b1; count_m++; last_m = v;
      seq_ptr = (seq_ptr == MAXN) ? 1 : seq_ptr + 1;
    end
    checks++; if (bus.draw_count !== 8'(count_m)) begin failures++; $display("FAIL bounce_count: got %0d expected %0d", bus.draw_count, count_m); end
    $display("bounce: strobes %0d first edge at %0d value %0d", ns, te, v);
  endtask

  task automatic test_exhaust();
    int ns, tb_, te; logic [7:0] v; bit w;
    test_draws(MAXN - count_m, "exhaust", 1'b1);
    checks++; if (bus.exhausted !== 1'b1) begin failures++; $display("FAIL exhausted_flag: got %0b expected 1", bus.exhausted); end
    checks++; if (bus.draw_count !== 8'(MAXN)) begin failures++; $display("FAIL exhausted_count: got %0d expected %0d", bus.draw_count, MAXN); end
    do_press(12, LIMIT, ns, tb_, te, v, w);
    checks++; if (ns != 0) begin failures++; $display("FAIL exhausted_strobe: got %0d expected 0", ns); end
    checks++; if (tb_ != -1) begin failures++; $display("FAIL exhausted_busy: got busy at %0d expected never", tb_); end
    checks++; if (bus.guessed_number !== last_m) begin failures++; $display("FAIL exhausted_value: got %0d expected %0d", bus.guessed_number, last_m); end
    checks++; if (bus.draw_count !== 8'(MAXN)) begin failures++; $display("FAIL exhausted_count_hold: got %0d expected %0d", bus.draw_count, MAXN); end
    $display("exhaust: extra press strobes %0d value held %0d", ns, bus.guessed_number);
  endtask

  task automatic test_new_game();
    int ns, tb_, te, seen, late; logic [7:0] v; bit w;
    bus.new_game = 1'b1; tick(); bus.new_game = 1'b0;
    model_clear();
    checks++; if (bus.draw_count !== 8'd0) begin failures++; $display("FAIL new_game_count: got %0d expected 0", bus.draw_count); end
    checks++; if (bus.exhausted !== 1'b0) begin failures++; $display("FAIL new_game_exhausted: got %0b expected 0", bus.exhausted); end
    checks++; if (bus.guessed_number !== last_m) begin failures++; $display("FAIL new_game_value_held: got %0d expected %0d", bus.guessed_number, last_m); end
    // new_game in the first DRAW cycle
    seen = 0;
    bus.btn_next = 1'b1;
    for (int n = 0; n < 20 && seen == 0; n++) begin tick(); if (bus.busy) seen = 1; end
    checks++; if (seen != 1) begin failures++; $display("FAIL collide_reach_draw: got %0d expected 1", seen); end
    bus.new_game = 1'b1; bus.btn_next = 1'b0;
    tick();
    bus.new_game = 1'b0;
    checks++; if (bus.next_edge !== 1'b0) begin failures++; $display("FAIL collide_next_edge: got %0b expected 0", bus.next_edge); end
    checks++; if (bus.draw_count !== 8'd0) begin failures++; $display("FAIL collide_count: got %0d expected 0", bus.draw_count); end
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL collide_busy: got %0b expected 0", bus.busy); end
    late = 0;
    repeat (30) begin tick(); if (bus.next_edge || bus.busy) late++; end
    checks++; if (late != 0) begin failures++; $display("FAIL collide_late_activity: got %0d cycles expected 0", late); end
    do_press(9, LIMIT, ns, tb_, te, v, w);
    checks++; if (ns != 1) begin failures++; $display("FAIL after_new_game_strobes: got %0d expected 1", ns); end
    checks++; if (v < 1 || v > MAXN) begin failures++; $display("FAIL after_new_game_range: got %0d expected 1..%0d", v, MAXN); end
    checks++; if (bus.draw_count !== 8'd1) begin failures++; $display("FAIL after_new_game_count: got %0d expected 1", bus.draw_count); end
    $display("new_game: collision suppressed, next draw value %0d", v);
  endtask

  task automatic test_reset_mid_draw();
    int seen, strobes;
    seen = 0;
    bus.btn_next = 1'b1;
    for (int n = 0; n < 20 && seen == 0; n++) begin tick(); if (bus.busy) seen = 1; end
    checks++; if (seen != 1) begin failures++; $display("FAIL rst_reach_draw: got %0d expected 1", seen); end
    rstn = 1'b0;
    tick();
    checks++; if (bus.guessed_number !== 8'd0) begin failures++; $display("FAIL rst_draw_guessed: got %0d expected 0", bus.guessed_number); end
    checks++; if (bus.next_edge !== 1'b0) begin failures++; $display("FAIL rst_draw_next_edge: got %0b expected 0", bus.next_edge); end
    checks++; if (bus.draw_count !== 8'd0) begin failures++; $display("FAIL rst_draw_count: got %0d expected 0", bus.draw_count); end
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL rst_draw_busy: got %0b expected 0", bus.busy); end
    checks++; if (bus.exhausted !== 1'b0) begin failures++; $display("FAIL rst_draw_exhausted: got %0b expected 0", bus.exhausted); end
    rstn = 1'b1;
    model_clear();
    strobes = 0;
    repeat (DEB + 2 + 300) begin tick(); if (bus.next_edge) strobes++; end
    checks++; if (strobes != 1) begin failures++; $display("FAIL held_after_reset_strobes: got %0d expected 1", strobes); end
    checks++; if (bus.draw_count !== 8'd1) begin failures++; $display("FAIL held_after_reset_count: got %0d expected 1", bus.draw_count); end
    bus.btn_next = 1'b0;
    repeat (4) tick();
    $display("reset_mid_draw: strobes while held after reset %0d", strobes);
  endtask

  initial begin
    rstn = 1'b0;
    bus.btn_next = 1'b0;
    bus.new_game = 1'b0;
    last_m = '0;
    test_reset();
    test_draws(3, "draws", 1'b1);
    test_bounce();
    test_exhaust();
    test_new_game();
    test_reset_mid_draw();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

  // Absolute time bound so the run always ends
  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
